// File: rtl/calc_controller_if.sv
// Character-buffer write port: valid/ready handshake carrying a buffer address and an ASCII code.
interface calc_controller_if #(
  parameter int unsigned ADDR_W = 11
);
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_char;

  modport master (output wr_valid, output wr_addr, output wr_char, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_char, output wr_ready);
endinterface

// File: rtl/calc_controller.sv
// Calculator sequencing controller: turns key presses and switch values into an
// operand-A / operand-B / result sequence and streams the shown value as four
// ASCII hex digits into the character buffer.
module calc_controller #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ADDR_W    = 11,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic [3:0]         i_key_n,
  input  logic [9:0]         i_sw,
  calc_controller_if.master  io_wr,
  output logic [2*WIDTH-1:0] o_result,
  output logic [1:0]         o_state,
  output logic               o_busy
);

  localparam int unsigned RW = 2 * WIDTH;

  typedef enum logic [1:0] {StA = 2'b00, StB = 2'b01, StRes = 2'b10} state_e;

  // Key conditioning (only enter and clear are used).
  logic [1:0] r_key_s1, r_key_s2, r_key_prev;
  logic [1:0] w_press;
  logic       w_enter, w_clear;

  // Main FSM.
  state_e           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, w_a_nxt, r_b, w_b_nxt;
  logic [1:0]       r_op, w_op_nxt;
  logic [RW-1:0]    r_result, w_result_nxt;
  logic [RW-1:0]    w_show_nxt;
  logic [RW-1:0]    w_opa, w_opb, w_alu;
  logic             w_trigger;

  // Display engine.
  logic          r_init, r_busy;
  logic [1:0]    r_idx;
  logic [RW-1:0] r_snap;
  logic [3:0]    w_nib;

  // B, op and the spare keys are kept for completeness but feed nothing.
  logic w_unused;
  assign w_unused = ^{i_key_n[3:2], r_b, r_op};

  // Two-flop synchronizer plus previous-value flop; released keys read as 1.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_key_s1   <= '1;
      r_key_s2   <= '1;
      r_key_prev <= '1;
    end else begin
      r_key_s1   <= i_key_n[1:0];
      r_key_s2   <= r_key_s1;
      r_key_prev <= r_key_s2;
    end
  end

  assign w_press = r_key_prev & ~r_key_s2;
  assign w_enter = w_press[0];
  assign w_clear = w_press[1];

  assign w_opa = RW'(r_a);
  assign w_opb = RW'(i_sw[WIDTH-1:0]);

  // Operator decode; operands zero-extended, results wrap at 2*WIDTH bits.
  always_comb begin
    case (i_sw[9:8])
      2'b00:   w_alu = w_opa + w_opb;
      2'b01:   w_alu = w_opa - w_opb;
      2'b10:   w_alu = w_opa * w_opb;
      default: w_alu = w_opa & w_opb;
    endcase
  end

  // Next-state logic; clear wins over enter, enter is dropped while a refresh runs.
  always_comb begin
    w_state_nxt  = r_state;
    w_a_nxt      = r_a;
    w_b_nxt      = r_b;
    w_op_nxt     = r_op;
    w_result_nxt = r_result;
    w_show_nxt   = r_snap;
    w_trigger    = r_init;  // automatic "0000" refresh on the first edge after reset
    if (w_clear) begin
      w_state_nxt  = StA;
      w_a_nxt      = '0;
      w_b_nxt      = '0;
      w_result_nxt = '0;
      w_show_nxt   = '0;
      w_trigger    = 1'b1;
    end else if (w_enter && !r_busy) begin
      w_trigger = 1'b1;
      case (r_state)
        StA: begin
          w_a_nxt     = i_sw[WIDTH-1:0];
          w_show_nxt  = RW'(i_sw[WIDTH-1:0]);
          w_state_nxt = StB;
        end
        StB: begin
          w_b_nxt      = i_sw[WIDTH-1:0];
          w_op_nxt     = i_sw[9:8];
          w_result_nxt = w_alu;
          w_show_nxt   = w_alu;
          w_state_nxt  = StRes;
        end
        StRes: begin
          // Chain the low half of the result into the next operand A.
          w_a_nxt     = r_result[WIDTH-1:0];
          w_show_nxt  = RW'(r_result[WIDTH-1:0]);
          w_state_nxt = StB;
        end
        default: begin
          w_show_nxt  = '0;
          w_state_nxt = StA;
        end
      endcase
    end
  end

  // Main FSM state and operand registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state  <= StA;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_result <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_a      <= w_a_nxt;
      r_b      <= w_b_nxt;
      r_op     <= w_op_nxt;
      r_result <= w_result_nxt;
    end
  end

  // Display engine: a trigger snapshots the shown value and restarts at digit 0.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_init <= 1'b1;
      r_busy <= 1'b0;
      r_idx  <= '0;
      r_snap <= '0;
    end else begin
      r_init <= 1'b0;
      if (w_trigger) begin
        r_snap <= w_show_nxt;
        r_idx  <= '0;
        r_busy <= 1'b1;
      end else if (r_busy && io_wr.wr_ready) begin
        r_idx <= r_idx + 2'd1;
        if (r_idx == 2'd3) r_busy <= 1'b0;
      end
    end
  end

  // Digit idx shows nibble (3-idx), i.e. most-significant first.
  assign w_nib = 4'(r_snap >> {~r_idx, 2'b00});

  // Nibble to ASCII hex.
  always_comb begin
    io_wr.wr_char = 8'h30;
    if (w_nib < 4'd10) io_wr.wr_char = 8'h30 + {4'h0, w_nib};
    else               io_wr.wr_char = 8'h37 + {4'h0, w_nib};
  end

  assign io_wr.wr_valid = r_busy;
  assign io_wr.wr_addr  = ADDR_W'(BASE_ADDR) + ADDR_W'(r_idx);
  assign o_result       = r_result;
  assign o_state        = r_state;
  assign o_busy         = r_busy;

endmodule

// File: tb/tb_calc_controller.sv
// Bench for calc_controller: table of enter/clear steps plus hand sequences for
// back-pressure, dropped enters, clear mid-refresh, held keys and async reset.
module tb_calc_controller;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  key_n;
  logic [9:0]  sw;
  logic [15:0] result;
  logic [1:0]  state;
  logic        busy;

  calc_controller_if #(.ADDR_W(11)) wr_if ();

  calc_controller #(.WIDTH(8), .ADDR_W(11), .BASE_ADDR(0)) dut (
    .i_clk    (clk),
    .i_reset_n(reset_n),
    .i_key_n  (key_n),
    .i_sw     (sw),
    .io_wr    (wr_if.master),
    .o_result (result),
    .o_state  (state),
    .o_busy   (busy)
  );

  always #5 clk = ~clk;

  // Write capture and busy-cycle count, sampled mid-cycle.
  logic [10:0] q_addr[$];
  logic [7:0]  q_char[$];
  int          busy_cnt = 0;

  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (wr_if.wr_valid && wr_if.wr_ready) begin
      q_addr.push_back(wr_if.wr_addr);
      q_char.push_back(wr_if.wr_char);
    end
  end

  int    total = 0;
  int    bad   = 0;
  string hexs  = "0123456789ABCDEF";

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Four writes since index wb, addresses 0..3, digits of exp_show MSB first.
  task automatic check_writes(input string name, input int wb, input logic [15:0] exp_show);
    logic [3:0] nib;
    check({name, ".nwr"}, q_char.size() - wb, 4);
    for (int i = 0; i < 4; i++) begin
      if (wb + i < q_char.size()) begin
        nib = exp_show[15-4*i -: 4];
        check($sformatf("%s.addr%0d", name, i), q_addr[wb+i], i);
        check($sformatf("%s.char%0d", name, i), q_char[wb+i], hexs[nib]);
      end
    end
  endtask

  task automatic wait_busy(input logic level, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk); #1;
      if (busy === level) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // One-cycle key press starting at the current (post-edge) time.
  task automatic press(input int k);
    key_n[k] = 1'b0;
    @(posedge clk); #1;
    key_n = 4'hF;
  endtask

  typedef struct {
    logic [9:0]  sw;
    bit          clr;
    logic [1:0]  st;
    logic [15:0] res;
    logic [15:0] show;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int wb, bb;
    bit ok;
    string nm;

    vecs[0] = '{10'h02C, 1'b0, 2'd1, 16'h0000, 16'h002C};
    vecs[1] = '{10'h005, 1'b0, 2'd2, 16'h0031, 16'h0031};
    vecs[2] = '{10'h000, 1'b0, 2'd1, 16'h0031, 16'h0031};
    vecs[3] = '{10'h000, 1'b1, 2'd0, 16'h0000, 16'h0000};
    vecs[4] = '{10'h003, 1'b0, 2'd1, 16'h0000, 16'h0003};
    vecs[5] = '{10'h105, 1'b0, 2'd2, 16'hFFFE, 16'hFFFE};
    vecs[6] = '{10'h000, 1'b0, 2'd1, 16'hFFFE, 16'h00FE};
    vecs[7] = '{10'h3F0, 1'b0, 2'd2, 16'h00F0, 16'h00F0};
    vecs[8] = '{10'h000, 1'b1, 2'd0, 16'h0000, 16'h0000};
    vecs[9] = '{10'h0FF, 1'b0, 2'd1, 16'h0000, 16'h00FF};

    reset_n = 1'b0;
    key_n = 4'hF;
    sw = '0;
    wr_if.wr_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst.valid", wr_if.wr_valid, 0);
    check("rst.busy", busy, 0);
    check("rst.addr", wr_if.wr_addr, 0);
    check("rst.char", wr_if.wr_char, 8'h30);
    check("rst.result", result, 0);
    check("rst.state", state, 0);

    // Automatic "0000" refresh after reset release.
    @(negedge clk);
    wb = q_char.size();
    bb = busy_cnt;
    reset_n = 1'b1;
    wait_busy(1'b1, 3, ok);
    check("init.rise", ok, 1);
    wait_busy(1'b0, 20, ok);
    check("init.done", ok, 1);
    check_writes("init", wb, 16'h0000);
    check("init.busycyc", busy_cnt - bb, 4);
    check("init.state", state, 0);

    // Table of enter/clear steps with wr_ready held high.
    foreach (vecs[i]) begin
      nm = $sformatf("vec%0d", i);
      sw = vecs[i].sw;
      wb = q_char.size();
      bb = busy_cnt;
      press(vecs[i].clr ? 1 : 0);
      wait_busy(1'b1, 5, ok);
      check({nm, ".rise"}, ok, 1);
      wait_busy(1'b0, 20, ok);
      check({nm, ".done"}, ok, 1);
      check({nm, ".state"}, state, vecs[i].st);
      check({nm, ".result"}, result, vecs[i].res);
      check({nm, ".busycyc"}, busy_cnt - bb, 4);
      check_writes(nm, wb, vecs[i].show);
    end

    // FF * FF with a 5-cycle stall on digit 1.
    sw = 10'h2FF;
    wb = q_char.size();
    bb = busy_cnt;
    press(0);
    wait_busy(1'b1, 5, ok);
    check("mul.rise", ok, 1);
    @(posedge clk); #1;
    wr_if.wr_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("stall%0d.valid", k), wr_if.wr_valid, 1);
      check($sformatf("stall%0d.addr", k), wr_if.wr_addr, 1);
      check($sformatf("stall%0d.char", k), wr_if.wr_char, 8'h45);
      @(posedge clk); #1;
    end
    wr_if.wr_ready = 1'b1;
    wait_busy(1'b0, 20, ok);
    check("mul.done", ok, 1);
    check("mul.state", state, 2);
    check("mul.result", result, 16'hFE01);
    check("mul.busycyc", busy_cnt - bb, 9);
    check_writes("mul", wb, 16'hFE01);

    // Enter during a stalled refresh is dropped.
    wr_if.wr_ready = 1'b0;
    sw = 10'h000;
    press(0);
    wait_busy(1'b1, 5, ok);
    check("drop.rise", ok, 1);
    check("drop.state1", state, 1);
    sw = 10'h0FF;
    press(0);
    repeat (4) @(posedge clk);
    #1;
    check("drop.state2", state, 1);
    check("drop.result", result, 16'hFE01);
    check("drop.valid", wr_if.wr_valid, 1);
    check("drop.addr", wr_if.wr_addr, 0);

    // Advance to digit 2, then clear restarts the refresh with "0000".
    wb = q_char.size();
    wr_if.wr_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    wr_if.wr_ready = 1'b0;
    check("clr.pre_addr", wr_if.wr_addr, 2);
    check("clr.pre_nwr", q_char.size() - wb, 2);
    wb = q_char.size();
    press(1);
    repeat (2) @(posedge clk);
    #1;
    check("clr.state", state, 0);
    check("clr.result", result, 0);
    check("clr.valid", wr_if.wr_valid, 1);
    check("clr.addr", wr_if.wr_addr, 0);
    check("clr.char", wr_if.wr_char, 8'h30);
    wr_if.wr_ready = 1'b1;
    wait_busy(1'b0, 20, ok);
    check("clr.done", ok, 1);
    check_writes("clr", wb, 16'h0000);

    // Enter held for 100 cycles acts once.
    sw = 10'h012;
    wb = q_char.size();
    bb = busy_cnt;
    key_n[0] = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    key_n = 4'hF;
    repeat (10) @(posedge clk);
    #1;
    check("hold.state", state, 1);
    check("hold.busycyc", busy_cnt - bb, 4);
    check_writes("hold", wb, 16'h0012);

    // Reset asserted mid-refresh drops outputs without a clock edge.
    wr_if.wr_ready = 1'b0;
    sw = 10'h034;
    press(0);
    wait_busy(1'b1, 5, ok);
    check("arst.rise", ok, 1);
    check("arst.pre_result", result, 16'h0046);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst.valid", wr_if.wr_valid, 0);
    check("arst.busy", busy, 0);
    check("arst.state", state, 0);
    check("arst.result", result, 0);
    @(negedge clk);
    wr_if.wr_ready = 1'b1;
    wb = q_char.size();
    reset_n = 1'b1;
    wait_busy(1'b1, 3, ok);
    check("arst.init_rise", ok, 1);
    wait_busy(1'b0, 20, ok);
    check("arst.init_done", ok, 1);
    check_writes("arst", wb, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/calc_controller.md
# calc_controller

Sequencing controller for the board-level calculator. It turns pushbutton presses and switch values into an operand-A / operand-B / result sequence and computes a 16-bit result. After every value change it streams four ASCII hex digits into the VGA character buffer through a valid/ready write port. It sits between the board I/O (KEY, SW) and the text buffer that the vga module scans out.

## Interface
- WIDTH, 8, operand width; result is 2*WIDTH = 16 bits
- ADDR_W, 11, character-buffer address width
- BASE_ADDR, 0, buffer address of the most-significant displayed digit

- clk  in  1  system clock (CLOCK_50 at top level)
- reset_n  in  1  asynchronous, active-low reset
- key_n  in  4  raw active-low pushbuttons; [0] enter, [1] clear, [3:2] unused
- sw  in  10  sw[7:0] operand value, sw[9:8] operator (00 add, 01 sub, 10 mul, 11 and)
- wr_ready  in  1  character buffer accepts a write this cycle
- wr_valid  out  1  character write pending
- wr_addr  out  ADDR_W  character address
- wr_char  out  8  ASCII character
- result  out  16  last computed result
- state  out  2  00 S_A, 01 S_B, 10 S_RES
- busy  out  1  display refresh in progress

## Operation
- Key conditioning: each key_n bit passes through a 2-flop synchronizer plus a previous-value flop. A press is a one-cycle pulse when the previous value is 1 and the synchronized value is 0. A held key produces exactly one pulse. No debounce.
- Main FSM registers: A, B (WIDTH each), op (2), result (16), show (16, the value to display).
- S_A, enter: A<=sw[7:0], show<={8'h00,sw[7:0]}, go to S_B, trigger refresh.
- S_B, enter: B<=sw[7:0], op<=sw[9:8], result<=f(A,sw), show<=same, go to S_RES, trigger refresh.
- S_RES, enter: A<=result[7:0], show<={8'h00,result[7:0]}, go to S_B, trigger refresh. This chains the result into the next operand.
- Arithmetic, with operands zero-extended to 16 bits and taken mod 2^16:
  - add: A+B
  - sub: A-B (3-5 = 16'hFFFE)
  - mul: full 16-bit product
  - and: {8'h00, A&B}
- Clear, in any state and even while busy: A, B, result, show <= 0; state <= S_A; trigger refresh.
- Enter while busy is ignored and dropped. Clear has priority over enter in the same cycle.
- Display engine:
  - A trigger snapshots show and sets idx=0, busy=1, wr_valid=1.
  - wr_addr = BASE_ADDR+idx. wr_char = hex of nibble (3-idx), most-significant first; 0-9 -> 8'h30-8'h39, A-F -> 8'h41-8'h46.
  - idx advances on wr_valid&wr_ready. After idx 3 is accepted, wr_valid and busy clear.
  - While wr_ready=0, wr_valid, wr_addr and wr_char hold stable. The only exception is a clear, which restarts at idx 0 with the new snapshot and abandons the unaccepted character.
- Reset: a refresh of "0000" is triggered automatically at the first clock edge after reset_n deasserts.

## Timing
- Reset values: wr_valid 0, busy 0, wr_addr BASE_ADDR, wr_char 8'h30, result 0, state 00. reset_n low clears all flops immediately, including mid-refresh.
- Key latency: key_n first sampled low at edge N -> press pulse during the cycle after N+1 -> FSM acts at edge N+2.
- At the acting edge, state, result and show update, and wr_valid rises (refresh starts on the same edge).
- With wr_ready tied high, a refresh takes exactly 4 cycles: busy and wr_valid high for cycles 1-4, low on cycle 5.
- An enter can be accepted no earlier than the edge at which busy returns low.

## Test plan
- Release reset with wr_ready=1 -> four consecutive writes, addr 0,1,2,3, chars 8'h30 x4, then wr_valid=0, state=00.
- sw=10'h02C, press enter -> state 01, writes "002C". Then sw=10'h005, enter -> result 16'h0031, state 10, writes "0031".
- A=8'h03, then sw=10'h105 (sub, B=5) -> result 16'hFFFE, chars 8'h46,8'h46,8'h46,8'h45. Enter again -> state 01, writes "00FE".
- A=8'hFF, sw=10'h2FF (mul) -> 16'hFE01. Hold wr_ready=0 for 5 cycles at idx 1 -> wr_valid=1, addr 1, char 8'h45 stable throughout; total refresh takes 9 cycles.
- Press enter during a refresh -> ignored, no state change. Press clear while idx=2 -> restart at idx 0 writing "0000", state 00, result 0.
- Hold key_n[0] low 100 cycles -> exactly one press pulse. Assert reset_n low mid-refresh -> wr_valid and busy drop without waiting for a clock edge.
